// File: rtl/enc_input_scheduler.sv
// rtl/enc_input_scheduler.sv - message-granular round-robin scheduler from the varint/raw FIFOs into the encoder core
module enc_input_scheduler #(
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             v_empty,
  input  logic [31:0]      v_data,
  input  logic             v_last,
  output logic             v_pop,
  input  logic             r_empty,
  input  logic [31:0]      r_data,
  input  logic [3:0]       r_wstrb,
  input  logic             r_last,
  output logic             r_pop,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic [31:0]      enc_data,
  output logic [3:0]       enc_wstrb,
  output logic             enc_last,
  output logic             enc_src,
  output logic             busy,
  output logic [CNT_W-1:0] v_msg_cnt,
  output logic [CNT_W-1:0] r_msg_cnt,
  output logic             err_overflow
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  localparam logic [2:0] S_IDLE   = 3'b001;
  localparam logic [2:0] S_XFER_V = 3'b010;
  localparam logic [2:0] S_XFER_R = 3'b100;

  logic [2:0]       state_q, state_d;
  logic             rr_raw_q, rr_raw_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic             err_q, err_d;

  logic             valid_q;
  logic [31:0]      data_q;
  logic [3:0]       wstrb_q;
  logic             last_q;
  logic             src_q;

  logic             in_v, in_r, out_free, pop;
  logic             w_last, at_max, msg_end;
  logic [31:0]      w_data;
  logic [3:0]       w_wstrb;
  logic [BW-1:0]    beat_inc;

  assign in_v     = (state_q == S_XFER_V);
  assign in_r     = (state_q == S_XFER_R);
  assign out_free = !valid_q || enc_ready;

  // Pops are gated by reset so the FIFOs are never disturbed while the block is held.
  assign v_pop = !reset && in_v && !v_empty && out_free;
  assign r_pop = !reset && in_r && !r_empty && out_free;
  assign pop   = v_pop || r_pop;

  assign w_data   = in_v ? v_data : r_data;
  assign w_wstrb  = in_v ? 4'hF   : r_wstrb;
  assign w_last   = in_v ? v_last : r_last;
  assign beat_inc = beat_q + BW'(1);
  assign at_max   = (beat_inc == BW'(MAX_BEATS));
  assign msg_end  = pop && (w_last || at_max);

  always_comb begin
    state_d  = state_q;
    rr_raw_d = rr_raw_q;
    beat_d   = beat_q;
    v_cnt_d  = v_cnt_q;
    r_cnt_d  = r_cnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        // rr_raw_q set means raw owned the last message, so varint wins a tie.
        if (enable) begin
          if (!v_empty && (r_empty || rr_raw_q)) begin
            state_d = S_XFER_V;
          end else if (!r_empty) begin
            state_d = S_XFER_R;
          end
        end
      end
      S_XFER_V, S_XFER_R: begin
        if (msg_end) begin
          state_d  = S_IDLE;
          beat_d   = '0;
          rr_raw_d = in_r;
          if (in_v) v_cnt_d = v_cnt_q + CNT_W'(1);
          else      r_cnt_d = r_cnt_q + CNT_W'(1);
          if (!w_last) err_d = 1'b1;
        end else if (pop) begin
          beat_d = beat_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_raw_q <= 1'b1;
      beat_q   <= '0;
      v_cnt_q  <= '0;
      r_cnt_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_raw_q <= rr_raw_d;
      beat_q   <= beat_d;
      v_cnt_q  <= v_cnt_d;
      r_cnt_q  <= r_cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      wstrb_q <= '0;
      last_q  <= 1'b0;
      src_q   <= 1'b0;
    end else if (pop) begin
      valid_q <= 1'b1;
      data_q  <= w_data;
      wstrb_q <= w_wstrb;
      last_q  <= w_last || at_max;
      src_q   <= in_r;
    end else if (enc_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign enc_valid    = valid_q;
  assign enc_data     = data_q;
  assign enc_wstrb    = wstrb_q;
  assign enc_last     = last_q;
  assign enc_src      = src_q;
  assign busy         = in_v || in_r;
  assign v_msg_cnt    = v_cnt_q;
  assign r_msg_cnt    = r_cnt_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_enc_input_scheduler.sv
// tb/tb_enc_input_scheduler.sv - directed bench for enc_input_scheduler with show-ahead FIFO models
module tb_enc_input_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        v_empty, v_last, v_pop;
  logic [31:0] v_data;
  logic        r_empty, r_last, r_pop;
  logic [31:0] r_data;
  logic [3:0]  r_wstrb;
  logic        enc_valid, enc_ready, enc_last, enc_src, busy, err_overflow;
  logic [31:0] enc_data;
  logic [3:0]  enc_wstrb;
  logic [15:0] v_msg_cnt, r_msg_cnt;

  enc_input_scheduler #(.MAX_BEATS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .v_empty(v_empty), .v_data(v_data), .v_last(v_last), .v_pop(v_pop),
    .r_empty(r_empty), .r_data(r_data), .r_wstrb(r_wstrb), .r_last(r_last), .r_pop(r_pop),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data), .enc_wstrb(enc_wstrb),
    .enc_last(enc_last), .enc_src(enc_src), .busy(busy),
    .v_msg_cnt(v_msg_cnt), .r_msg_cnt(r_msg_cnt), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] data; logic [3:0] wstrb; logic last;} fw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] wstrb; logic last; logic src;} ow_t;
  typedef struct {
    logic en, rdy, vpop, valid, last, busy;
    logic [31:0] data;
    logic [15:0] vcnt;
  } vec_t;

  fw_t vq[$];
  fw_t rq[$];
  ow_t rx[$];
  ow_t expq[$];
  vec_t tbl[6];

  int total = 0;
  int bad = 0;
  int vpop_total, rpop_total;
  logic vp, rp, toggle_rdy, hold_pending;
  ow_t hold_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_pins();
    v_empty = (vq.size() == 0);
    r_empty = (rq.size() == 0);
    {v_data, v_last} = v_empty ? 33'd0 : {vq[0].data, vq[0].last};
    {r_data, r_wstrb, r_last} = r_empty ? 37'd0 : {rq[0].data, rq[0].wstrb, rq[0].last};
  endtask

  function automatic ow_t cur_out();
    cur_out = '{data: enc_data, wstrb: enc_wstrb, last: enc_last, src: enc_src};
  endfunction

  task automatic to_negedge();
    @(negedge clk);
    vp = v_pop;
    rp = r_pop;
    if (hold_pending) begin
      check("hold_valid", {63'd0, enc_valid}, 64'd1);
      check("hold_word", {26'd0, cur_out()}, {26'd0, hold_word});
    end
    hold_pending = enc_valid && !enc_ready && !reset;
    hold_word = cur_out();
    if (enc_valid && enc_ready) rx.push_back(cur_out());
    vpop_total += int'(vp);
    rpop_total += int'(rp);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
    if (vp) begin
      if (vq.size() == 0) begin total++; bad++; $display("FAIL v_pop_on_empty"); end
      else void'(vq.pop_front());
    end
    if (rp) begin
      if (rq.size() == 0) begin total++; bad++; $display("FAIL r_pop_on_empty"); end
      else void'(rq.pop_front());
    end
    if (toggle_rdy) enc_ready = ~enc_ready;
    update_pins();
  endtask

  task automatic step();
    to_negedge();
    finish_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vq.delete();
    rq.delete();
    update_pins();
    step();
    step();
    reset = 1'b0;
    rx.delete();
    expq.delete();
    hold_pending = 1'b0;
    vpop_total = 0;
    rpop_total = 0;
  endtask

  task automatic run_words(input string name, input int n, input int budget);
    int cyc = 0;
    while (rx.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    repeat (3) step();
    check({name, "_count"}, rx.size(), expq.size());
    for (int i = 0; i < rx.size() && i < expq.size(); i++)
      check($sformatf("%s_w%0d", name, i), {26'd0, rx[i]}, {26'd0, expq[i]});
  endtask

  function automatic fw_t fw(input logic [31:0] d, input logic [3:0] s, input logic l);
    fw = '{data: d, wstrb: s, last: l};
  endfunction

  function automatic ow_t ow(input logic [31:0] d, input logic [3:0] s, input logic l, input logic src);
    ow = '{data: d, wstrb: s, last: l, src: src};
  endfunction

  initial begin
    // en rdy vpop valid last busy data vcnt, for a 3-word varint message loaded while IDLE
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_0001, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_0002, 16'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_0003, 16'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         16'd1};

    reset = 1'b1; enable = 1'b1; enc_ready = 1'b1; toggle_rdy = 1'b0;
    hold_pending = 1'b0; vpop_total = 0; rpop_total = 0;
    update_pins();
    do_reset();

    to_negedge();
    check("rst_outputs", {enc_valid, enc_last, enc_src, busy, v_pop, r_pop, err_overflow}, 0);
    check("rst_data", {enc_data, enc_wstrb}, 0);
    check("rst_cnts", {v_msg_cnt, r_msg_cnt}, 0);
    finish_cycle();

    vq.push_back(fw(32'h1111_0001, 4'h0, 1'b0));
    vq.push_back(fw(32'h1111_0002, 4'h0, 1'b0));
    vq.push_back(fw(32'h1111_0003, 4'h0, 1'b1));
    update_pins();
    for (int i = 0; i < 6; i++) begin
      enable = tbl[i].en;
      enc_ready = tbl[i].rdy;
      to_negedge();
      check($sformatf("t1_vpop%0d", i), {63'd0, v_pop}, {63'd0, tbl[i].vpop});
      check($sformatf("t1_rpop%0d", i), {63'd0, r_pop}, 64'd0);
      check($sformatf("t1_valid%0d", i), {63'd0, enc_valid}, {63'd0, tbl[i].valid});
      check($sformatf("t1_busy%0d", i), {63'd0, busy}, {63'd0, tbl[i].busy});
      check($sformatf("t1_vcnt%0d", i), {48'd0, v_msg_cnt}, {48'd0, tbl[i].vcnt});
      if (tbl[i].valid)
        check($sformatf("t1_word%0d", i), {26'd0, cur_out()}, {26'd0, ow(tbl[i].data, 4'hF, tbl[i].last, 1'b0)});
      finish_cycle();
    end

    // two 2-word messages in each FIFO, alternating by message
    do_reset();
    for (int m = 0; m < 2; m++) begin
      vq.push_back(fw(32'hA000_0000 + 32'(m * 2),     4'h0, 1'b0));
      vq.push_back(fw(32'hA000_0001 + 32'(m * 2),     4'h0, 1'b1));
      rq.push_back(fw(32'hB000_0000 + 32'(m * 2),     4'h1, 1'b0));
      rq.push_back(fw(32'hB000_0001 + 32'(m * 2),     4'h7, 1'b1));
    end
    update_pins();
    for (int m = 0; m < 2; m++) begin
      expq.push_back(ow(32'hA000_0000 + 32'(m * 2), 4'hF, 1'b0, 1'b0));
      expq.push_back(ow(32'hA000_0001 + 32'(m * 2), 4'hF, 1'b1, 1'b0));
      expq.push_back(ow(32'hB000_0000 + 32'(m * 2), 4'h1, 1'b0, 1'b1));
      expq.push_back(ow(32'hB000_0001 + 32'(m * 2), 4'h7, 1'b1, 1'b1));
    end
    run_words("t2_rr", 8, 60);
    check("t2_cnts", {v_msg_cnt, r_msg_cnt}, {16'd2, 16'd2});

    // raw message under a toggling ready
    do_reset();
    rq.push_back(fw(32'hC000_0001, 4'h3, 1'b0));
    rq.push_back(fw(32'hC000_0002, 4'hF, 1'b0));
    rq.push_back(fw(32'hC000_0003, 4'h3, 1'b1));
    update_pins();
    expq.push_back(ow(32'hC000_0001, 4'h3, 1'b0, 1'b1));
    expq.push_back(ow(32'hC000_0002, 4'hF, 1'b0, 1'b1));
    expq.push_back(ow(32'hC000_0003, 4'h3, 1'b1, 1'b1));
    toggle_rdy = 1'b1;
    run_words("t3_toggle", 3, 40);
    toggle_rdy = 1'b0;
    enc_ready = 1'b1;
    check("t3_rcnt", {48'd0, r_msg_cnt}, 64'd1);

    // overflow with raw empty: the tail becomes a second varint message
    do_reset();
    for (int i = 1; i <= 6; i++) vq.push_back(fw(32'hD000_0000 + 32'(i), 4'h0, i == 6));
    update_pins();
    for (int i = 1; i <= 6; i++) expq.push_back(ow(32'hD000_0000 + 32'(i), 4'hF, (i == 4) || (i == 6), 1'b0));
    check("t4_err_before", {63'd0, err_overflow}, 64'd0);
    run_words("t4_ovf", 6, 40);
    check("t4_err", {63'd0, err_overflow}, 64'd1);
    check("t4_vcnt", {48'd0, v_msg_cnt}, 64'd2);

    // overflow with a raw message waiting: raw is granted before the tail
    do_reset();
    for (int i = 1; i <= 6; i++) vq.push_back(fw(32'hE000_0000 + 32'(i), 4'h0, i == 6));
    rq.push_back(fw(32'hE100_0001, 4'h5, 1'b1));
    update_pins();
    for (int i = 1; i <= 4; i++) expq.push_back(ow(32'hE000_0000 + 32'(i), 4'hF, i == 4, 1'b0));
    expq.push_back(ow(32'hE100_0001, 4'h5, 1'b1, 1'b1));
    expq.push_back(ow(32'hE000_0005, 4'hF, 1'b0, 1'b0));
    expq.push_back(ow(32'hE000_0006, 4'hF, 1'b1, 1'b0));
    run_words("t4_ovf_rr", 7, 50);
    check("t4b_cnts", {v_msg_cnt, r_msg_cnt, 15'd0, err_overflow}, {16'd2, 16'd1, 16'd1});

    // reset while raw holds a stalled word
    do_reset();
    enc_ready = 1'b0;
    for (int i = 1; i <= 3; i++) rq.push_back(fw(32'hF000_0000 + 32'(i), 4'h9, i == 3));
    update_pins();
    begin
      int cyc = 0;
      to_negedge();
      while (!enc_valid && cyc < 10) begin
        finish_cycle();
        to_negedge();
        cyc++;
      end
      check("t5_valid_reached", {63'd0, enc_valid}, 64'd1);
      check("t5_src", {63'd0, enc_src}, 64'd1);
      finish_cycle();
    end
    reset = 1'b1;
    to_negedge();
    check("t5_no_pop_in_reset", {62'd0, v_pop, r_pop}, 64'd0);
    finish_cycle();
    to_negedge();
    check("t5_rst_outputs", {enc_valid, enc_last, enc_src, busy, v_pop, r_pop, err_overflow}, 0);
    check("t5_rst_data", {enc_data, enc_wstrb}, 0);
    check("t5_fifo_kept", rq.size(), 2);
    finish_cycle();
    enc_ready = 1'b1;

    // enable drops after the first varint word
    do_reset();
    for (int i = 1; i <= 3; i++) vq.push_back(fw(32'h5000_0000 + 32'(i), 4'h0, i == 3));
    rq.push_back(fw(32'h6000_0001, 4'hA, 1'b1));
    update_pins();
    begin
      int cyc = 0;
      while (vpop_total == 0 && cyc < 10) begin
        step();
        cyc++;
      end
      check("t6_first_pop", (vpop_total > 0), 1);
    end
    enable = 1'b0;
    repeat (12) step();
    for (int i = 1; i <= 3; i++) expq.push_back(ow(32'h5000_0000 + 32'(i), 4'hF, i == 3, 1'b0));
    check("t6_msg_done", rx.size(), 3);
    check("t6_no_raw_pop", rpop_total, 0);
    check("t6_raw_waiting", rq.size(), 1);
    check("t6_idle", {63'd0, busy}, 64'd0);
    enable = 1'b1;
    expq.push_back(ow(32'h6000_0001, 4'hA, 1'b1, 1'b1));
    run_words("t6_resume", 4, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc_input_scheduler.md
Name: enc_input_scheduler

Overview:
- Drains the varint_in and raw_data_in input FIFOs, which the AXI4 write front end fills, into the single shared encoder core.
- Arbitrates at message granularity using round-robin. Once a source is granted, all its words are forwarded up to and including the word flagged last.
- Presents a registered valid/ready stream to the encoder and keeps per-source message counters plus an overflow error flag.

Parameters:
- MAX_BEATS, 256: maximum words per message; the next word beyond this is force-terminated.
- CNT_W, 16: width of the message counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  permits new grants; does not stop a message in progress
- v_empty  in  1  varint FIFO empty; show-ahead, so v_data and v_last are valid when low
- v_data  in  32  varint FIFO head word
- v_last  in  1  head word ends a varint message (written via the last address)
- v_pop  out  1  pop varint FIFO (data, index and last together)
- r_empty  in  1  raw-data FIFO empty; show-ahead
- r_data  in  32  raw-data FIFO head word
- r_wstrb  in  4  raw-data head byte strobes
- r_last  in  1  head word ends a raw message
- r_pop  out  1  pop raw-data FIFO
- enc_valid  out  1  output word valid
- enc_ready  in  1  encoder accepts word
- enc_data  out  32  output word
- enc_wstrb  out  4  strobes; 4'hF for varint words
- enc_last  out  1  message end
- enc_src  out  1  0 = varint, 1 = raw
- busy  out  1  high in XFER_V or XFER_R
- v_msg_cnt  out  CNT_W  completed varint messages; wraps
- r_msg_cnt  out  CNT_W  completed raw messages; wraps
- err_overflow  out  1  sticky; a message exceeded MAX_BEATS

Behaviour:
- Reset state:
  - State IDLE; all outputs 0; round-robin pointer prefers varint.
  - Counters 0; err_overflow 0; beat counter 0.
  - A word held in the output register is discarded. FIFO contents are untouched.
- States are one-hot: IDLE, XFER_V, XFER_R.
- IDLE:
  - Stays in IDLE if enable=0 or both FIFOs are empty.
  - If only one FIFO is non-empty, that source is granted.
  - If both are non-empty, the source not granted last is granted.
  - Grant moves to XFER_V or XFER_R on the next edge. No pop occurs in IDLE.
- Pop condition in XFER_x: x_empty=0 and (enc_valid=0 or enc_ready=1).
  - x_pop is combinational and high for one cycle per word.
  - On the same edge the output register loads data, strobes, last and src, and enc_valid=1.
- enc_valid holding rule:
  - enc_valid and its data remain stable until enc_ready=1.
  - On ready without a new pop, enc_valid clears.
  - On ready with a new pop, the register reloads. Back-to-back throughput is 1 word/cycle.
- Latency: FIFO non-empty in IDLE gives a pop one cycle later, and enc_valid the cycle after the pop edge (two edges total).
- Popped word with last=1:
  - Return to IDLE, record the granted source for round-robin, and increment that source's msg_cnt.
  - Counters wrap from 2^CNT_W-1 to 0.
  - The next grant occurs at the earliest one cycle after the IDLE entry. No word from the new source appears before enc_last of the previous message has been loaded.
- Beat counter:
  - Counts words popped in the current message; cleared on each IDLE entry.
  - If the word that makes the count equal MAX_BEATS has last=0, it is output with enc_last=1 (forced).
  - On that event err_overflow sets (sticky until reset), msg_cnt increments, and the state returns to IDLE.
- FIFO empty mid-message: stay in XFER_x without popping and wait. No timeout.
- enable deasserted mid-message: the current message completes; no new grant is issued.
- Varint words always output enc_wstrb=4'hF; raw words pass r_wstrb unchanged.
- The non-granted FIFO is never popped.

Test Plan:
- Single varint message of 3 words (last on the third), enc_ready=1 → v_pop on 3 consecutive cycles; enc_last only on word 3; enc_src=0; v_msg_cnt=1; state back in IDLE.
- Both FIFOs hold two 2-word messages → output order V,V,R,R,V,V,R,R; each message contiguous; v_msg_cnt=2, r_msg_cnt=2.
- Raw message with enc_ready toggling 1010 → every word held stable while enc_ready=0; no word lost or duplicated; r_wstrb values (4'h3, 4'hF) passed unchanged.
- MAX_BEATS=4, varint message of 6 words with last on word 6 → word 4 has enc_last=1 and err_overflow=1. Words 5–6 are a new varint message only if raw is empty; otherwise raw is granted first.
- Reset asserted while XFER_R has enc_valid=1 → next cycle all outputs 0; state IDLE; FIFOs not popped during reset.
- enable=0 after the first word of a 3-word message → the message completes; a pending raw message is not granted until enable=1.
